// File: rtl/ibutterfly2_dif.sv
// Radix-2 DIF inverse butterfly: out0=(a+b)/2, out1=((a-b)*conj(W))/2.
// One shared real multiplier, sequenced over four states; valid/ready both sides.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_valid / o_in_ready           input handshake (pair a,b and twiddle W)
//   i_in0_re/im, i_in1_re/im       operands a, b   (N-bit two's complement)
//   i_twiddle_re/im                twiddle W, conjugated internally (Q frac bits)
//   o_valid / i_ready              output handshake
//   o_out0_re/im, o_out1_re/im     results, held stable while o_valid=1
//   o_busy                         FSM not idle
module ibutterfly2_dif #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in0_re,
    input  logic [N-1:0] i_in0_im,
    input  logic [N-1:0] i_in1_re,
    input  logic [N-1:0] i_in1_im,
    input  logic [N-1:0] i_twiddle_re,
    input  logic [N-1:0] i_twiddle_im,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_out0_re,
    output logic [N-1:0] o_out0_im,
    output logic [N-1:0] o_out1_re,
    output logic [N-1:0] o_out1_im,
    output logic         o_busy
);

    localparam int PW = 2*N + 1;
    localparam int AW = 2*N + 2;

    localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(N-1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2**(N-1)));

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched operands: sum and difference are formed at accept time,
    // so later input changes cannot disturb the operation in flight.
    logic signed [N:0]    s_re;
    logic signed [N:0]    s_im;
    logic signed [N:0]    d_re;
    logic signed [N:0]    d_im;
    logic signed [N-1:0]  w_re;
    logic signed [N-1:0]  w_im;

    logic signed [AW-1:0] acc_re;
    logic signed [AW-1:0] acc_im;

    logic signed [N:0]    mul_a;
    logic signed [N-1:0]  mul_b;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_x;
    logic signed [AW-1:0] acc_im_fin;

    // Scale by 2^-(Q+1): Q undoes the twiddle format, the extra 1 is the
    // per-stage halving. Clamp rather than wrap.
    function automatic logic [N-1:0] sat_scale(
        input logic signed [AW-1:0] v
    );
        logic signed [AW-1:0] sh;
        sh = v >>> (Q + 1);
        if (sh > SAT_MAX) begin
            sat_scale = SAT_MAX[N-1:0];
        end else if (sh < SAT_MIN) begin
            sat_scale = SAT_MIN[N-1:0];
        end else begin
            sat_scale = sh[N-1:0];
        end
    endfunction

    assign o_in_ready = (state_q == IDLE);
    assign o_busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = M0;
            M0:      state_d = M1;
            M1:      state_d = M2;
            M2:      state_d = M3;
            M3:      state_d = OUT;
            OUT:     if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand select for the single multiplier.
    always_comb begin
        mul_a = d_re;
        mul_b = w_re;
        unique case (state_q)
            M1: begin
                mul_a = d_im;
                mul_b = w_im;
            end
            M2: begin
                mul_a = d_im;
                mul_b = w_re;
            end
            M3: begin
                mul_a = d_re;
                mul_b = w_im;
            end
            default: begin
                mul_a = d_re;
                mul_b = w_re;
            end
        endcase
    end

    assign prod       = PW'(mul_a) * PW'(mul_b);
    assign prod_x     = AW'(prod);
    assign acc_im_fin = acc_im - prod_x;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s_re      <= '0;
            s_im      <= '0;
            d_re      <= '0;
            d_im      <= '0;
            w_re      <= '0;
            w_im      <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            o_valid   <= 1'b0;
            o_out0_re <= '0;
            o_out0_im <= '0;
            o_out1_re <= '0;
            o_out1_im <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        s_re <= {i_in0_re[N-1], i_in0_re}
                              + {i_in1_re[N-1], i_in1_re};
                        s_im <= {i_in0_im[N-1], i_in0_im}
                              + {i_in1_im[N-1], i_in1_im};
                        d_re <= {i_in0_re[N-1], i_in0_re}
                              - {i_in1_re[N-1], i_in1_re};
                        d_im <= {i_in0_im[N-1], i_in0_im}
                              - {i_in1_im[N-1], i_in1_im};
                        w_re <= i_twiddle_re;
                        w_im <= i_twiddle_im;
                    end
                end
                M0: acc_re <= prod_x;
                M1: acc_re <= acc_re + prod_x;
                M2: acc_im <= prod_x;
                M3: begin
                    acc_im    <= acc_im_fin;
                    // S is N+1 bits, so dropping its LSB is an exact
                    // floor halving that always fits N bits.
                    o_out0_re <= s_re[N:1];
                    o_out0_im <= s_im[N:1];
                    o_out1_re <= sat_scale(acc_re);
                    o_out1_im <= sat_scale(acc_im_fin);
                    o_valid   <= 1'b1;
                end
                OUT: begin
                    if (i_ready) o_valid <= 1'b0;
                end
                default: o_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ibutterfly2_dif.sv
// Directed bench for ibutterfly2_dif: hand-computed vectors, backpressure,
// mid-operation reset and a back-to-back run against a reference model.
module tb_ibutterfly2_dif;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_in_ready;
    logic [15:0] i_in0_re;
    logic [15:0] i_in0_im;
    logic [15:0] i_in1_re;
    logic [15:0] i_in1_im;
    logic [15:0] i_twiddle_re;
    logic [15:0] i_twiddle_im;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_out0_re;
    logic [15:0] o_out0_im;
    logic [15:0] o_out1_re;
    logic [15:0] o_out1_im;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ibutterfly2_dif #(.N(16), .Q(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_in0_re     (i_in0_re),
        .i_in0_im     (i_in0_im),
        .i_in1_re     (i_in1_re),
        .i_in1_im     (i_in1_im),
        .i_twiddle_re (i_twiddle_re),
        .i_twiddle_im (i_twiddle_im),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_out0_re    (o_out0_re),
        .o_out0_im    (o_out0_im),
        .o_out1_re    (o_out1_re),
        .o_out1_im    (o_out1_im),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else                 return 16'(v);
    endfunction

    task automatic model(input  logic [15:0] ar, ai, br, bi, wr, wi,
                         output logic [15:0] o0r, o0i, o1r, o1i);
        longint a_r, a_i, b_r, b_i, w_r, w_i, dr, di, pr, pi;
        a_r = longint'($signed(ar));
        a_i = longint'($signed(ai));
        b_r = longint'($signed(br));
        b_i = longint'($signed(bi));
        w_r = longint'($signed(wr));
        w_i = longint'($signed(wi));
        o0r = 16'((a_r + b_r) >>> 1);
        o0i = 16'((a_i + b_i) >>> 1);
        dr  = a_r - b_r;
        di  = a_i - b_i;
        pr  = dr * w_r + di * w_i;
        pi  = di * w_r - dr * w_i;
        o1r = sat16(pr >>> 9);
        o1i = sat16(pi >>> 9);
    endtask

    task automatic set_in(input logic [15:0] ar, ai, br, bi, wr, wi);
        i_in0_re     = ar;
        i_in0_im     = ai;
        i_in1_re     = br;
        i_in1_im     = bi;
        i_twiddle_re = wr;
        i_twiddle_im = wi;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!o_in_ready && k < 20) begin
            @(posedge i_clk); #1;
            k++;
        end
        if (!o_in_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Present a vector, accept it, scramble the inputs, wait for o_valid.
    task automatic send(input string tag,
                        input logic [15:0] ar, ai, br, bi, wr, wi);
        int k = 0;
        set_in(ar, ai, br, bi, wr, wi);
        i_valid = 1'b1;
        wait_ready(tag);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        set_in(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 16'hCDEF);
        while (!o_valid && k < 20) begin
            @(posedge i_clk); #1;
            k++;
        end
        check({tag, "_latency"}, k, 4);
    endtask

    task automatic expect_out(input string tag,
                              input logic [15:0] e0r, e0i, e1r, e1i);
        check({tag, "_out0_re"}, o_out0_re, e0r);
        check({tag, "_out0_im"}, o_out0_im, e0i);
        check({tag, "_out1_re"}, o_out1_re, e1r);
        check({tag, "_out1_im"}, o_out1_im, e1i);
    endtask

    task automatic drain(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, "_valid_drop"}, o_valid, 0);
        check({tag, "_ready_back"}, o_in_ready, 1);
    endtask

    logic [15:0] e0r, e0i, e1r, e1i;
    logic [15:0] vr [8][6];
    int          last_acc;

    initial begin
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        expect_out("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("rst_in_ready", o_in_ready, 1);

        // 1. plain real case
        send("t1", 16'h0100, 16'h0000, 16'h0080, 16'h0000,
             16'h0100, 16'h0000);
        expect_out("t1", 16'h00C0, 16'h0000, 16'h0040, 16'h0000);
        check("t1_busy", o_busy, 1);
        drain("t1");

        // 2. W = -j, conjugated to +j
        send("t2", 16'h0100, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'hFF00);
        expect_out("t2", 16'h0080, 16'h0000, 16'h0000, 16'h0080);
        drain("t2");

        // 3. saturation, both signs
        send("t3p", 16'h7FFF, 16'h0000, 16'h8000, 16'h0000,
             16'h7FFF, 16'h0000);
        expect_out("t3p", 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000);
        drain("t3p");
        send("t3n", 16'h8000, 16'h0000, 16'h7FFF, 16'h0000,
             16'h7FFF, 16'h0000);
        expect_out("t3n", 16'hFFFF, 16'h0000, 16'h8000, 16'h0000);
        drain("t3n");

        // 4. backpressure; fresh input offered but must not be taken
        send("t4", 16'h0200, 16'h0100, 16'h0100, 16'hFF00,
             16'h0100, 16'h0000);
        // a-b = 0100+j0200, W=1 -> out1 = 0080+j0100
        expect_out("t4", 16'h0180, 16'h0000, 16'h0080, 16'h0100);
        set_in(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000);
        i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            check("t4_hold_valid", o_valid, 1);
            check("t4_hold_inrdy", o_in_ready, 0);
            expect_out("t4_hold", 16'h0180, 16'h0000, 16'h0080, 16'h0100);
        end
        i_valid = 1'b0;
        drain("t4");

        // 5. reset while in M2
        set_in(16'h0300, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
        i_valid = 1'b1;
        wait_ready("t5");
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("t5_in_m2", o_busy, 1);
        i_rst = 1'b0;
        #1;
        check("t5_rst_busy", o_busy, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        check("t5_idle", o_in_ready, 1);
        check("t5_valid", o_valid, 0);
        expect_out("t5_rst", 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (6) @(posedge i_clk);
        #1;
        check("t5_discard", o_valid, 0);
        send("t5b", 16'h0100, 16'h0000, 16'h0080, 16'h0000,
             16'h0100, 16'h0000);
        expect_out("t5b", 16'h00C0, 16'h0000, 16'h0040, 16'h0000);
        drain("t5b");

        // 6. back-to-back against the reference model
        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 6; j++) vr[v][j] = 16'($urandom);
        end
        vr[0][4] = 16'h0100;
        vr[0][5] = 16'h0000;
        vr[1][0] = 16'h7FFF;
        vr[1][1] = 16'h8000;
        vr[1][2] = 16'h8000;
        vr[1][3] = 16'h7FFF;
        i_ready = 1'b1;
        i_valid = 1'b1;
        last_acc = 0;
        for (int v = 0; v < 8; v++) begin
            int k;
            set_in(vr[v][0], vr[v][1], vr[v][2], vr[v][3],
                   vr[v][4], vr[v][5]);
            wait_ready("t6");
            @(posedge i_clk); #1;
            if (v > 0) check("t6_period", cyc - last_acc, 6);
            last_acc = cyc;
            k = 0;
            while (!o_valid && k < 20) begin
                @(posedge i_clk); #1;
                k++;
            end
            check("t6_latency", k, 4);
            model(vr[v][0], vr[v][1], vr[v][2], vr[v][3],
                  vr[v][4], vr[v][5], e0r, e0i, e1r, e1i);
            expect_out($sformatf("t6_v%0d", v), e0r, e0i, e1r, e1i);
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        check("t6_end_valid", o_valid, 0);
        i_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
